// File: rtl/macc_filter_pkg.sv
// Shared constants and types for the single-MAC FIR filter
// and its coefficient loader.
package macc_filter_pkg;

    localparam int COEFF_W  = 18;
    localparam int ADDR_W   = 4;
    localparam int NUM_TAPS = 16;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CSUM,
        ST_WRITE
    } ldr_state_e;

    // Bytes per coefficient on the wire.
    function automatic int bpc(input int w);
        return (w + 7) / 8;
    endfunction

endpackage

// File: rtl/macc_coeff_shadow.sv
// Shadow copy of one full coefficient set, filled byte-stream side
// and read back during the RAM write burst.
module macc_coeff_shadow
    import macc_filter_pkg::*;
(
    input  logic               Clk_i,
    input  logic               RstN_i,
    input  logic               Clr_i,
    input  logic               We_i,
    input  logic [ADDR_W-1:0]  WAddr_i,
    input  logic [COEFF_W-1:0] WData_i,
    input  logic [ADDR_W-1:0]  RAddr_i,
    output logic [COEFF_W-1:0] RData_o
);

    logic [COEFF_W-1:0] mem_q [NUM_TAPS];

    // Clear on reset or frame start, otherwise single write port.
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            for (int i = 0; i < NUM_TAPS; i++) mem_q[i] <= '0;
        end else if (Clr_i) begin
            for (int i = 0; i < NUM_TAPS; i++) mem_q[i] <= '0;
        end else if (We_i && (int'(WAddr_i) < NUM_TAPS)) begin
            mem_q[WAddr_i] <= WData_i;
        end
    end

    // Addresses beyond the tap count read as zero.
    always_comb begin
        RData_o = '0;
        if (int'(RAddr_i) < NUM_TAPS) RData_o = mem_q[RAddr_i];
    end

endmodule

// File: rtl/macc_coeff_loader.sv
// Framed byte-stream coefficient loader: buffers and checks a full set,
// then burst-writes every tap address of the filter coefficient RAM.
module macc_coeff_loader
    import macc_filter_pkg::*;
(
    input  logic               Clk_i,
    input  logic               RstN_i,
    input  logic [7:0]         ByteData_i,
    input  logic               ByteValid_i,
    output logic               ByteReady_o,
    output logic [ADDR_W-1:0]  CoeffAddr_o,
    output logic [COEFF_W-1:0] CoeffData_o,
    output logic               CoeffWr_o,
    output logic               Busy_o,
    output logic               Done_o,
    output logic               Err_o
);

    localparam int BPC = bpc(COEFF_W);
    localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;

    localparam logic [7:0]        MAX_N  = 8'(NUM_TAPS);
    localparam logic [BW-1:0]     LAST_B = BW'(BPC - 1);
    localparam logic [BW-1:0]     ONE_B  = BW'(1);
    localparam logic [ADDR_W:0]   ONE_N  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_K = ADDR_W'(NUM_TAPS - 1);

    ldr_state_e state_q, state_d;

    logic [ADDR_W:0]    n_q, n_d;
    logic [BW-1:0]      bi_q, bi_d;
    logic [ADDR_W-1:0]  ci_q, ci_d;
    logic [ADDR_W-1:0]  wk_q, wk_d;
    logic [COEFF_W-9:0] asm_q, asm_d;
    logic [7:0]         csum_q, csum_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic               accept;
    logic [COEFF_W-1:0] word;
    logic               sh_we;
    logic               sh_clr;
    logic               wr;
    logic [COEFF_W-1:0] sh_rdata;

    // Only the low COEFF_W bits of each big-endian word survive the shift.
    assign word   = {asm_q, ByteData_i};
    assign accept = ByteValid_i & ByteReady_o;

    macc_coeff_shadow u_shadow (
        .Clk_i   (Clk_i),
        .RstN_i  (RstN_i),
        .Clr_i   (sh_clr),
        .We_i    (sh_we),
        .WAddr_i (ci_q),
        .WData_i (word),
        .RAddr_i (wk_q),
        .RData_o (sh_rdata)
    );

    // State and datapath registers.
    always_ff @(posedge Clk_i or negedge RstN_i) begin
        if (!RstN_i) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            bi_q    <= '0;
            ci_q    <= '0;
            wk_q    <= '0;
            asm_q   <= '0;
            csum_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            bi_q    <= bi_d;
            ci_q    <= ci_d;
            wk_q    <= wk_d;
            asm_q   <= asm_d;
            csum_q  <= csum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Frame parser, checksum and write-burst sequencing.
    always_comb begin
        state_d     = state_q;
        n_d         = n_q;
        bi_d        = bi_q;
        ci_d        = ci_q;
        wk_d        = wk_q;
        asm_d       = asm_q;
        csum_d      = csum_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        sh_we       = 1'b0;
        sh_clr      = 1'b0;
        wr          = 1'b0;
        ByteReady_o = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && ByteData_i == SYNC_BYTE) begin
                    state_d = ST_COUNT;
                    csum_d  = '0;
                    sh_clr  = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    if (ByteData_i == 8'd0 || ByteData_i > MAX_N) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        n_d     = ByteData_i[ADDR_W:0];
                        csum_d  = csum_q + ByteData_i;
                        bi_d    = '0;
                        ci_d    = '0;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    asm_d  = word[COEFF_W-9:0];
                    csum_d = csum_q + ByteData_i;
                    if (bi_q == LAST_B) begin
                        bi_d  = '0;
                        sh_we = 1'b1;
                        if ({1'b0, ci_q} == n_q - ONE_N) state_d = ST_CSUM;
                        else ci_d = ci_q + ONE_A;
                    end else begin
                        bi_d = bi_q + ONE_B;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (ByteData_i == csum_q) begin
                        wk_d    = '0;
                        state_d = ST_WRITE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WRITE: begin
                ByteReady_o = 1'b0;
                wr          = 1'b1;
                if (wk_q == LAST_K) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    wk_d = wk_q + ONE_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port is forced to zero outside the burst.
    always_comb begin
        CoeffWr_o   = wr;
        CoeffAddr_o = wr ? wk_q : '0;
        CoeffData_o = wr ? sh_rdata : '0;
        Busy_o      = (state_q != ST_IDLE);
        Done_o      = done_q;
        Err_o       = err_q;
    end

endmodule

// File: tb/tb_macc_coeff_loader.sv
// Self-checking bench for macc_coeff_loader: frame table plus a
// write scoreboard fed by a reference frame parser.
module tb_macc_coeff_loader;
    import macc_filter_pkg::*;

    logic               Clk_i = 1'b0;
    logic               RstN_i = 1'b0;
    logic [7:0]         ByteData_i = 8'h00;
    logic               ByteValid_i = 1'b0;
    logic               ByteReady_o;
    logic [ADDR_W-1:0]  CoeffAddr_o;
    logic [COEFF_W-1:0] CoeffData_o;
    logic               CoeffWr_o;
    logic               Busy_o;
    logic               Done_o;
    logic               Err_o;

    always #5 Clk_i = ~Clk_i;

    macc_coeff_loader dut (
        .Clk_i       (Clk_i),
        .RstN_i      (RstN_i),
        .ByteData_i  (ByteData_i),
        .ByteValid_i (ByteValid_i),
        .ByteReady_o (ByteReady_o),
        .CoeffAddr_o (CoeffAddr_o),
        .CoeffData_o (CoeffData_o),
        .CoeffWr_o   (CoeffWr_o),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .Err_o       (Err_o)
    );

    typedef struct {
        logic [ADDR_W-1:0]  a;
        logic [COEFF_W-1:0] d;
    } wr_t;

    typedef struct {
        string      name;
        int         len;
        logic [7:0] b [80];
        int         gap;
        int         e_err;
        int         e_done;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int err_cnt = 0;
    int done_cnt = 0;
    int acc_cyc = 0;
    int done_cyc = -1;
    int first_wr_cyc = -1;

    wr_t        exp_q [$];
    vec_t       vecs [10];
    int         nv = 0;
    logic [7:0] q [$];

    always @(posedge Clk_i) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write scoreboard and pulse monitor.
    always @(negedge Clk_i) begin
        if (RstN_i) begin
            if (Done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (Err_o) err_cnt++;
            if (Done_o || Err_o) chk("done_err_excl", Done_o & Err_o, 0);
            if (CoeffWr_o) begin
                chk("wr_ready_low", ByteReady_o, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h",
                             CoeffAddr_o, CoeffData_o);
                end else begin
                    wr_t w;
                    w = exp_q.pop_front();
                    chk("wr_addr", CoeffAddr_o, w.a);
                    chk("wr_data", CoeffData_o, w.d);
                    if (w.a == '0) first_wr_cyc = cyc;
                end
            end
        end
    end

    task automatic add_vec(input string nm, input int gap,
                           input int e_err, input int e_done);
        vecs[nv].name   = nm;
        vecs[nv].len    = q.size();
        vecs[nv].gap    = gap;
        vecs[nv].e_err  = e_err;
        vecs[nv].e_done = e_done;
        for (int i = 0; i < q.size(); i++) vecs[nv].b[i] = q[i];
        nv++;
    endtask

    // Reference parser: pushes the expected burst of a good frame.
    task automatic model_frame(input int v);
        logic [COEFF_W-1:0] sh [NUM_TAPS];
        int st = 0;
        int n = 0;
        int cnt = 0;
        int sum = 0;
        int word = 0;
        for (int i = 0; i < vecs[v].len; i++) begin
            int b;
            b = int'(vecs[v].b[i]);
            case (st)
                0: if (b == 'hA5) begin
                    st = 1;
                    for (int k = 0; k < NUM_TAPS; k++) sh[k] = '0;
                end
                1: if (b == 0 || b > NUM_TAPS) st = 0;
                   else begin
                       n = b; sum = b; cnt = 0; word = 0; st = 2;
                   end
                2: begin
                    word = ((word << 8) | b) & 'hFFFFFF;
                    sum  = sum + b;
                    cnt++;
                    if (cnt % 3 == 0) sh[cnt / 3 - 1] = COEFF_W'(word);
                    if (cnt == 3 * n) st = 3;
                end
                default: begin
                    if (b == (sum & 'hFF))
                        for (int k = 0; k < NUM_TAPS; k++)
                            exp_q.push_back('{a: ADDR_W'(k), d: sh[k]});
                    st = 0;
                end
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        @(negedge Clk_i);
        ByteData_i  = b;
        ByteValid_i = 1'b1;
        while (!ByteReady_o && t < 100) begin
            @(negedge Clk_i);
            t++;
        end
        if (t >= 100) chk("send_timeout", t, 0);
        @(posedge Clk_i);
        #1;
        acc_cyc     = cyc;
        ByteValid_i = 1'b0;
    endtask

    task automatic send_vec(input int v);
        for (int i = 0; i < vecs[v].len; i++) begin
            repeat ($urandom_range(0, vecs[v].gap)) @(negedge Clk_i);
            send_byte(vecs[v].b[i]);
        end
    endtask

    task automatic run_vec(input int v);
        int e0;
        int d0;
        e0 = err_cnt;
        d0 = done_cnt;
        done_cyc = -1;
        first_wr_cyc = -1;
        model_frame(v);
        send_vec(v);
        repeat (NUM_TAPS + 4) @(negedge Clk_i);
        chk({vecs[v].name, "_err"}, err_cnt - e0, vecs[v].e_err);
        chk({vecs[v].name, "_done"}, done_cnt - d0, vecs[v].e_done);
        chk({vecs[v].name, "_pending"}, exp_q.size(), 0);
        chk({vecs[v].name, "_busy"}, Busy_o, 0);
        if (vecs[v].e_done != 0) begin
            chk({vecs[v].name, "_first_wr_lat"}, first_wr_cyc - acc_cyc, 0);
            chk({vecs[v].name, "_done_lat"}, done_cyc - acc_cyc, NUM_TAPS);
        end
    endtask

    initial begin
        logic [7:0] s;

        repeat (3) @(negedge Clk_i);
        RstN_i = 1'b1;
        @(negedge Clk_i);
        chk("rst_ready", ByteReady_o, 1);
        chk("rst_wr", CoeffWr_o, 0);
        chk("rst_addr", CoeffAddr_o, 0);
        chk("rst_data", CoeffData_o, 0);
        chk("rst_busy", Busy_o, 0);
        chk("rst_done", Done_o, 0);
        chk("rst_err", Err_o, 0);

        q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h04};
        add_vec("good", 0, 0, 1);
        q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h05};
        add_vec("bad_csum", 0, 1, 0);
        q = {8'hA5, 8'h11};
        add_vec("cnt_17", 0, 1, 0);
        q = {8'hA5, 8'h00};
        add_vec("cnt_0", 0, 1, 0);
        q = {8'hA5, 8'h02, 8'h00, 8'h00, 8'h01, 8'h03, 8'hFF, 8'hFF, 8'h04};
        add_vec("good_after_err", 1, 0, 1);
        q = {8'h00, 8'h5A, 8'hFF, 8'hA5, 8'h02, 8'h00, 8'h00, 8'h01,
             8'h03, 8'hFF, 8'hFF, 8'h04};
        add_vec("garbage", 0, 0, 1);
        q = {8'hA5, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hF0};
        add_vec("sync_in_data", 0, 0, 1);
        q = {8'hA5, 8'h10};
        s = 8'h10;
        for (int k = 0; k < NUM_TAPS; k++) begin
            q.push_back(8'h00);
            q.push_back(8'h00);
            q.push_back(8'(k));
            s = s + 8'(k);
        end
        q.push_back(s);
        add_vec("full16", 3, 0, 1);

        for (int v = 0; v < nv; v++) run_vec(v);

        // Reset in the middle of a burst with a byte held valid.
        model_frame(0);
        send_vec(0);
        ByteData_i  = 8'hA5;
        ByteValid_i = 1'b1;
        begin
            int t = 0;
            while (!(CoeffWr_o && CoeffAddr_o == 5) && t < 40) begin
                @(negedge Clk_i);
                t++;
            end
            chk("mid_wr_reach_k5", t < 40, 1);
        end
        #1;
        RstN_i = 1'b0;
        #1;
        chk("mid_rst_wr", CoeffWr_o, 0);
        chk("mid_rst_addr", CoeffAddr_o, 0);
        chk("mid_rst_data", CoeffData_o, 0);
        chk("mid_rst_busy", Busy_o, 0);
        chk("mid_rst_done", Done_o, 0);
        chk("mid_rst_err", Err_o, 0);
        chk("mid_rst_ready", ByteReady_o, 1);
        exp_q.delete();
        ByteValid_i = 1'b0;
        repeat (2) @(negedge Clk_i);
        RstN_i = 1'b1;
        @(negedge Clk_i);

        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
